// File: rtl/marker_event_tracker.sv
// ----------------------------------------------------------------------------
// marker_event_tracker
//
// Watches the retire lanes of the core for marker instructions
// (slti x0,x0,imm with imm 0..14) and turns them into phase events.
// Each marker opens or closes one of seven phases, or requests the end of
// the simulation. The block keeps per-phase open flags and cycle-length
// counters, and queues one timestamped record per marker in a small FIFO
// that a consumer drains over a valid/ready handshake.
//
// Ports:
//   clock         - clock
//   reset         - asynchronous, active-low reset
//   commit_valid  - per-lane retire valid
//   commit_inst   - per-lane retired instruction, lane i at [32i+31:32i]
//   evt_valid     - FIFO head holds a record
//   evt_ready     - consumer accepts the head record
//   evt_data      - head record {timestamp, lane, code[3:0], err}
//   phase_active  - per-phase open flag, bit p = phase p
//   cnt_sel       - phase counter select (0..6, others read 0)
//   cnt_rdata     - length counter of the selected phase
//   drop_cnt      - records lost to a full FIFO, saturating
//   exit_req      - sticky exit request
//
// Phase numbering: 0 VCTM, 1 DELAY, 2 TEXE, 3 LEAK, 4 INIT, 5 BIM, 6 TRAIN.
// Marker code = imm[3:0]; even codes start phase code>>1, odd codes end it,
// code 14 is SIM_EXIT.
// ----------------------------------------------------------------------------
module marker_event_tracker #(
    parameter int COMMIT_W     = 2,
    parameter int TIME_W       = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int STOP_ON_TEXE = 0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [COMMIT_W-1:0]               commit_valid,
    input  logic [32*COMMIT_W-1:0]            commit_inst,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic [TIME_W+$clog2(COMMIT_W)+4:0] evt_data,
    output logic [6:0]                        phase_active,
    input  logic [2:0]                        cnt_sel,
    output logic [TIME_W-1:0]                 cnt_rdata,
    output logic [15:0]                       drop_cnt,
    output logic                              exit_req
);

    localparam int LANE_W = $clog2(COMMIT_W);
    localparam int REST_W = LANE_W + 5;
    localparam int REC_W  = TIME_W + REST_W;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int IDX_W  = (AW > 0) ? AW : 1;
    localparam int CNT_W  = AW + 1;
    localparam int NPH    = 7;

    localparam logic [3:0]     CODE_EXIT       = 4'd14;
    localparam logic [3:0]     CODE_TEXE_START = 4'd4;
    localparam logic [CNT_W:0] DEPTH_V         = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W:0] ONE_SLOT        = (CNT_W+1)'(1);

    logic [TIME_W-1:0]   timestamp;
    logic [CNT_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic [REC_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [TIME_W-1:0]   phase_cnt [NPH];

    logic [COMMIT_W-1:0] lane_match;
    logic [COMMIT_W-1:0] lane_err;
    logic [COMMIT_W-1:0] push_en;
    logic [3:0]          lane_code [COMMIT_W];
    logic [IDX_W-1:0]    push_addr [COMMIT_W];
    logic [REC_W-1:0]    lane_rec  [COMMIT_W];

    logic [NPH-1:0]      open_next;
    logic [NPH-1:0]      start_seen;
    logic                exit_hit;
    logic                pop;
    logic [CNT_W:0]      free_slots;
    logic [CNT_W:0]      push_total;
    logic [15:0]         drop_now;
    logic [16:0]         drop_sum;

    // Pointers carry one extra wrap bit; only the low bits address storage.
    // Masking keeps a single-entry FIFO addressing slot 0.
    function automatic logic [IDX_W-1:0] fifo_index(input logic [CNT_W-1:0] ptr);
        logic [CNT_W-1:0] masked;
        masked = ptr & CNT_W'(FIFO_DEPTH - 1);
        return masked[IDX_W-1:0];
    endfunction

    // Marker decode. imm <= 14 on the full 12-bit field also guarantees
    // that inst[31:24] is zero.
    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            lane_code[i]  = commit_inst[32*i+20 +: 4];
            lane_match[i] = commit_valid[i]
                          && (commit_inst[32*i +: 20] == 20'h02013)
                          && (commit_inst[32*i+20 +: 12] <= 12'd14);
        end
    end

    // Phase bookkeeping walks the lanes in order so that a later lane sees
    // the open/closed state left behind by an earlier lane of the same cycle.
    always_comb begin
        open_next  = phase_active;
        start_seen = '0;
        lane_err   = '0;
        exit_hit   = 1'b0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (lane_match[i]) begin
                if (lane_code[i] == CODE_EXIT) begin
                    exit_hit = 1'b1;
                end else if (!lane_code[i][0]) begin
                    lane_err[i]                   = open_next[lane_code[i][3:1]];
                    open_next[lane_code[i][3:1]]  = 1'b1;
                    start_seen[lane_code[i][3:1]] = 1'b1;
                    if ((STOP_ON_TEXE != 0) && (lane_code[i] == CODE_TEXE_START)) begin
                        exit_hit = 1'b1;
                    end
                end else begin
                    lane_err[i]                  = !open_next[lane_code[i][3:1]];
                    open_next[lane_code[i][3:1]] = 1'b0;
                end
            end
        end
    end

    // Record layout: {timestamp, lane, code, err}.
    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            lane_rec[i] = {timestamp,
                           REST_W'(i << 5) | REST_W'({lane_code[i], lane_err[i]})};
        end
    end

    assign fifo_count = wr_ptr - rd_ptr;
    assign evt_valid  = (fifo_count != '0);
    assign pop        = evt_valid && evt_ready;
    assign evt_data   = fifo_mem[fifo_index(rd_ptr)];

    // Free space counts the slot vacated by this cycle's pop, so a full
    // FIFO that is being drained can still accept one record.
    assign free_slots = DEPTH_V - {1'b0, fifo_count} + {{CNT_W{1'b0}}, pop};

    // Lowest lanes claim free slots first; whatever does not fit is dropped.
    always_comb begin
        push_total = '0;
        drop_now   = '0;
        push_en    = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            push_addr[i] = '0;
            if (lane_match[i]) begin
                if (push_total < free_slots) begin
                    push_en[i]   = 1'b1;
                    push_addr[i] = fifo_index(wr_ptr + push_total[CNT_W-1:0]);
                    push_total   = push_total + ONE_SLOT;
                end else begin
                    drop_now = drop_now + 16'd1;
                end
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + {1'b0, drop_now};

    // Record storage has no reset; validity comes from the pointers alone.
    always_ff @(posedge clock) begin
        for (int i = 0; i < COMMIT_W; i++) begin
            if (push_en[i]) begin
                fifo_mem[push_addr[i]] <= lane_rec[i];
            end
        end
    end

    // Timestamp, FIFO pointers, phase state and status registers. A phase
    // counter counts cycles the phase was already open; any START in the
    // cycle restarts it from zero instead.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timestamp    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            phase_active <= '0;
            drop_cnt     <= '0;
            exit_req     <= 1'b0;
            for (int p = 0; p < NPH; p++) begin
                phase_cnt[p] <= '0;
            end
        end else begin
            timestamp    <= timestamp + TIME_W'(1);
            wr_ptr       <= wr_ptr + push_total[CNT_W-1:0];
            if (pop) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
            phase_active <= open_next;
            drop_cnt     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (exit_hit) begin
                exit_req <= 1'b1;
            end
            for (int p = 0; p < NPH; p++) begin
                if (start_seen[p]) begin
                    phase_cnt[p] <= '0;
                end else if (phase_active[p] && (phase_cnt[p] != '1)) begin
                    phase_cnt[p] <= phase_cnt[p] + TIME_W'(1);
                end
            end
        end
    end

    // Counter readback; selects beyond the last phase read zero.
    always_comb begin
        cnt_rdata = '0;
        if (cnt_sel < 3'd7) begin
            cnt_rdata = phase_cnt[cnt_sel];
        end
    end

endmodule

// File: tb/tb_marker_event_tracker.sv
// ----------------------------------------------------------------------------
// tb_marker_event_tracker
//
// Directed bench for marker_event_tracker with two commit lanes and an
// eight-entry FIFO. A second instance with STOP_ON_TEXE=1 shares every input
// so the TEXE exit option can be compared against the default build.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_marker_event_tracker;

    localparam int REC_W = 38;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        commit_valid;
    logic [63:0]       commit_inst;
    logic              evt_ready;
    logic [2:0]        cnt_sel;

    logic              evt_valid;
    logic [REC_W-1:0]  evt_data;
    logic [6:0]        phase_active;
    logic [31:0]       cnt_rdata;
    logic [15:0]       drop_cnt;
    logic              exit_req;

    logic              t_evt_valid;
    logic [REC_W-1:0]  t_evt_data;
    logic [6:0]        t_phase_active;
    logic [31:0]       t_cnt_rdata;
    logic [15:0]       t_drop_cnt;
    logic              t_exit_req;

    int                checks   = 0;
    int                failures = 0;
    logic [31:0]       tb_ts;
    logic [31:0]       cur_ts;
    logic [31:0]       t0;
    logic [31:0]       t1;
    logic [31:0]       t2;
    logic [REC_W-1:0]  exp_q [$];

    typedef struct packed {
        logic [1:0]  valid;
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic [1:0]  n;
        logic        a_lane;
        logic [3:0]  a_code;
        logic        a_err;
        logic        b_lane;
        logic [3:0]  b_code;
        logic        b_err;
        logic [6:0]  pa;
        logic        texe_exit;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    marker_event_tracker #(
        .COMMIT_W(2), .TIME_W(32), .FIFO_DEPTH(8), .STOP_ON_TEXE(0)
    ) dut (
        .clock(clock), .reset(reset),
        .commit_valid(commit_valid), .commit_inst(commit_inst),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .phase_active(phase_active), .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata),
        .drop_cnt(drop_cnt), .exit_req(exit_req)
    );

    marker_event_tracker #(
        .COMMIT_W(2), .TIME_W(32), .FIFO_DEPTH(8), .STOP_ON_TEXE(1)
    ) dut_texe (
        .clock(clock), .reset(reset),
        .commit_valid(commit_valid), .commit_inst(commit_inst),
        .evt_valid(t_evt_valid), .evt_ready(evt_ready), .evt_data(t_evt_data),
        .phase_active(t_phase_active), .cnt_sel(cnt_sel), .cnt_rdata(t_cnt_rdata),
        .drop_cnt(t_drop_cnt), .exit_req(t_exit_req)
    );

    // Free-running clock, posedge at 5, 15, 25 ...
    always #5 clock = ~clock;

    // Reference cycle number: the timestamp a record committed now must carry.
    always @(posedge clock or negedge reset) begin
        if (!reset) tb_ts <= 32'd0;
        else        tb_ts <= tb_ts + 32'd1;
    end

    // Hard stop in case something never returns.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [REC_W-1:0] mkRec(input logic [31:0] ts, input logic lane,
                                               input logic [3:0] code, input logic err);
        return {ts, lane, code, err};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one commit cycle starting at a negedge and returns on the next
    // negedge with the lanes idle again.
    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] i0,
                                 input logic [31:0] i1, output logic [31:0] ts);
        commit_valid = v;
        commit_inst  = {i1, i0};
        ts           = tb_ts;
        @(negedge clock);
        commit_valid = 2'b00;
        commit_inst  = 64'h0;
    endtask

    task automatic popRecord(input string name, input logic [REC_W-1:0] rec);
        checkOutput({name, "_valid"}, 64'(evt_valid), 64'(1'b1));
        checkOutput(name, 64'(evt_data), 64'(rec));
        evt_ready = 1'b1;
        @(negedge clock);
        evt_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2'b01, 32'h00002013, 32'h00000000, 2'd1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 7'h01, 1'b0};
        vecs[1]  = '{2'b10, 32'h00000000, 32'h00102013, 2'd1, 1'b1, 4'd1,  1'b0, 1'b0, 4'd0,  1'b0, 7'h00, 1'b0};
        vecs[2]  = '{2'b11, 32'h00402013, 32'h00502013, 2'd2, 1'b0, 4'd4,  1'b0, 1'b1, 4'd5,  1'b0, 7'h00, 1'b1};
        vecs[3]  = '{2'b01, 32'h00102013, 32'h00000000, 2'd1, 1'b0, 4'd1,  1'b1, 1'b0, 4'd0,  1'b0, 7'h00, 1'b1};
        vecs[4]  = '{2'b11, 32'h00002093, 32'h00f02013, 2'd0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 7'h00, 1'b1};
        vecs[5]  = '{2'b10, 32'h00002013, 32'h00c02013, 2'd1, 1'b1, 4'd12, 1'b0, 1'b0, 4'd0,  1'b0, 7'h40, 1'b1};
        vecs[6]  = '{2'b01, 32'h00c02013, 32'h00000000, 2'd1, 1'b0, 4'd12, 1'b1, 1'b0, 4'd0,  1'b0, 7'h40, 1'b1};
        vecs[7]  = '{2'b11, 32'h00d02013, 32'h00d02013, 2'd2, 1'b0, 4'd13, 1'b0, 1'b1, 4'd13, 1'b1, 7'h00, 1'b1};
        vecs[8]  = '{2'b11, 32'h00802013, 32'h00602013, 2'd2, 1'b0, 4'd8,  1'b0, 1'b1, 4'd6,  1'b0, 7'h18, 1'b1};
        vecs[9]  = '{2'b11, 32'h00902013, 32'h00702013, 2'd2, 1'b0, 4'd9,  1'b0, 1'b1, 4'd7,  1'b0, 7'h00, 1'b1};
        vecs[10] = '{2'b11, 32'h00a02013, 32'h00b02013, 2'd2, 1'b0, 4'd10, 1'b0, 1'b1, 4'd11, 1'b0, 7'h00, 1'b1};
        vecs[11] = '{2'b11, 32'h10002013, 32'h00302013, 2'd1, 1'b1, 4'd3,  1'b1, 1'b0, 4'd0,  1'b0, 7'h00, 1'b1};

        commit_valid = 2'b00;
        commit_inst  = 64'h0;
        evt_ready    = 1'b0;
        cnt_sel      = 3'd0;

        // Reset state while reset is held low.
        repeat (2) @(negedge clock);
        checkOutput("rst_evt_valid", 64'(evt_valid), 64'(1'b0));
        checkOutput("rst_phase_active", 64'(phase_active), 64'(7'h00));
        checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'(16'h0));
        checkOutput("rst_exit_req", 64'(exit_req), 64'(1'b0));
        checkOutput("rst_cnt_rdata", 64'(cnt_rdata), 64'(32'h0));
        reset = 1'b1;

        // VCTM opened at timestamp 5 and closed at timestamp 12.
        repeat (5) @(negedge clock);
        applyStimulus(2'b01, 32'h00002013, 32'h0, cur_ts);
        for (int c = 6; c <= 12; c++) begin
            checkOutput($sformatf("vctm_open_ts%0d", c), 64'(phase_active[0]), 64'(1'b1));
            if (c == 6) checkOutput("push_latency_valid", 64'(evt_valid), 64'(1'b1));
            if (c < 12) @(negedge clock);
        end
        applyStimulus(2'b10, 32'h0, 32'h00102013, cur_ts);
        checkOutput("vctm_closed", 64'(phase_active), 64'(7'h00));
        cnt_sel = 3'd0;
        #1;
        checkOutput("vctm_length", 64'(cnt_rdata), 64'(32'd7));
        cnt_sel = 3'd7;
        #1;
        checkOutput("cnt_sel7_zero", 64'(cnt_rdata), 64'(32'd0));
        cnt_sel = 3'd0;
        popRecord("rec_vctm_start", mkRec(32'd5, 1'b0, 4'd0, 1'b0));
        popRecord("rec_vctm_end", mkRec(32'd12, 1'b1, 4'd1, 1'b0));
        checkOutput("vctm_fifo_empty", 64'(evt_valid), 64'(1'b0));

        // Table of single-cycle commit patterns.
        for (int k = 0; k < NV; k++) begin
            applyStimulus(vecs[k].valid, vecs[k].inst0, vecs[k].inst1, cur_ts);
            checkOutput($sformatf("v%0d_phase_active", k), 64'(phase_active), 64'(vecs[k].pa));
            checkOutput($sformatf("v%0d_exit_req", k), 64'(exit_req), 64'(1'b0));
            checkOutput($sformatf("v%0d_texe_exit_req", k), 64'(t_exit_req), 64'(vecs[k].texe_exit));
            if (vecs[k].n >= 2'd1)
                popRecord($sformatf("v%0d_rec_a", k),
                          mkRec(cur_ts, vecs[k].a_lane, vecs[k].a_code, vecs[k].a_err));
            if (vecs[k].n >= 2'd2)
                popRecord($sformatf("v%0d_rec_b", k),
                          mkRec(cur_ts, vecs[k].b_lane, vecs[k].b_code, vecs[k].b_err));
            checkOutput($sformatf("v%0d_fifo_empty", k), 64'(evt_valid), 64'(1'b0));
        end

        // START of an already open VCTM flags err and restarts its counter.
        cnt_sel = 3'd0;
        applyStimulus(2'b01, 32'h00002013, 32'h0, t0);
        checkOutput("restart_cnt_first", 64'(cnt_rdata), 64'(32'd0));
        repeat (2) @(negedge clock);
        checkOutput("restart_cnt_before", 64'(cnt_rdata), 64'(32'd2));
        applyStimulus(2'b01, 32'h00002013, 32'h0, t1);
        checkOutput("restart_cnt_zero", 64'(cnt_rdata), 64'(32'd0));
        checkOutput("restart_still_open", 64'(phase_active), 64'(7'h01));
        @(negedge clock);
        checkOutput("restart_cnt_one", 64'(cnt_rdata), 64'(32'd1));
        applyStimulus(2'b01, 32'h00102013, 32'h0, t2);
        checkOutput("restart_closed", 64'(phase_active), 64'(7'h00));
        checkOutput("restart_cnt_final", 64'(cnt_rdata), 64'(32'd2));
        popRecord("rec_restart_open", mkRec(t0, 1'b0, 4'd0, 1'b0));
        popRecord("rec_restart_err", mkRec(t1, 1'b0, 4'd0, 1'b1));
        popRecord("rec_restart_end", mkRec(t2, 1'b0, 4'd1, 1'b0));

        // Overflow: ten matches into eight slots, then streaming on a full FIFO.
        evt_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(2'b11, 32'h00002013, 32'h00102013, cur_ts);
            if (c < 4) begin
                exp_q.push_back(mkRec(cur_ts, 1'b0, 4'd0, 1'b0));
                exp_q.push_back(mkRec(cur_ts, 1'b1, 4'd1, 1'b0));
            end
        end
        checkOutput("ovf_drop_cnt", 64'(drop_cnt), 64'(16'd2));
        checkOutput("ovf_full_valid", 64'(evt_valid), 64'(1'b1));
        checkOutput("ovf_head_hold0", 64'(evt_data), 64'(exp_q[0]));
        @(negedge clock);
        checkOutput("ovf_head_hold1", 64'(evt_data), 64'(exp_q[0]));
        evt_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("ovf_stream_head%0d", c), 64'(evt_data), 64'(exp_q.pop_front()));
            applyStimulus(2'b01, (c % 2 == 0) ? 32'h00202013 : 32'h00302013, 32'h0, cur_ts);
            exp_q.push_back(mkRec(cur_ts, 1'b0, (c % 2 == 0) ? 4'd2 : 4'd3, 1'b0));
        end
        checkOutput("ovf_no_new_drops", 64'(drop_cnt), 64'(16'd2));
        while (exp_q.size() > 0) begin
            checkOutput("drain_valid", 64'(evt_valid), 64'(1'b1));
            checkOutput("drain_data", 64'(evt_data), 64'(exp_q.pop_front()));
            @(negedge clock);
        end
        evt_ready = 1'b0;
        checkOutput("drain_empty", 64'(evt_valid), 64'(1'b0));

        // SIM_EXIT on lane 1 raises a sticky exit request.
        checkOutput("exit_before", 64'(exit_req), 64'(1'b0));
        applyStimulus(2'b10, 32'h0, 32'h00e02013, cur_ts);
        checkOutput("exit_set", 64'(exit_req), 64'(1'b1));
        checkOutput("exit_no_phase", 64'(phase_active), 64'(7'h00));
        popRecord("rec_exit", mkRec(cur_ts, 1'b1, 4'd14, 1'b0));
        repeat (3) @(negedge clock);
        checkOutput("exit_sticky", 64'(exit_req), 64'(1'b1));
        checkOutput("texe_exit_sticky", 64'(t_exit_req), 64'(1'b1));

        // Reset asserted mid-stream clears state without a clock edge.
        cnt_sel = 3'd4;
        applyStimulus(2'b01, 32'h00802013, 32'h0, cur_ts);
        @(negedge clock);
        checkOutput("pre_rst_init_cnt", 64'(cnt_rdata), 64'(32'd1));
        checkOutput("pre_rst_phase", 64'(phase_active), 64'(7'h10));
        checkOutput("pre_rst_valid", 64'(evt_valid), 64'(1'b1));
        checkOutput("pre_rst_drop", 64'(drop_cnt), 64'(16'd2));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_rst_valid", 64'(evt_valid), 64'(1'b0));
        checkOutput("async_rst_phase", 64'(phase_active), 64'(7'h00));
        checkOutput("async_rst_drop", 64'(drop_cnt), 64'(16'd0));
        checkOutput("async_rst_exit", 64'(exit_req), 64'(1'b0));
        checkOutput("async_rst_cnt", 64'(cnt_rdata), 64'(32'd0));
        checkOutput("async_rst_texe_exit", 64'(t_exit_req), 64'(1'b0));
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
